// File: rtl/mm_pkg.sv
// Shared types for the main-memory read arbiter: widths, read owner tags and
// the round-robin state encoding.
package mm_pkg;

  localparam int MM_AW = 19;
  localparam int MM_DW = 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VGA = 1'b1
  } owner_e;

  typedef enum logic {
    LAST_CPU = 1'b0,
    LAST_VGA = 1'b1
  } rr_state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/mm_arbiter_if.sv
// Bus bundle between the CPU, the VGA fetch unit, the arbiter and the RAM.
// slave = arbiter view, master = requesters/RAM view.
interface mm_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 8
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          vga_req;
  logic          vga_urgent;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;

  logic [AW-1:0] mm_raddr;
  logic [AW-1:0] mm_waddr;
  logic [DW-1:0] mm_wdata;
  logic          mm_wren;
  logic [DW-1:0] mm_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vga_req, vga_urgent, vga_addr,
    input  mm_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output vga_gnt, vga_rvalid, vga_rdata,
    output mm_raddr, mm_waddr, mm_wdata, mm_wren
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vga_req, vga_urgent, vga_addr,
    output mm_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  vga_gnt, vga_rvalid, vga_rdata,
    input  mm_raddr, mm_waddr, mm_wdata, mm_wren
  );

endinterface

// File: rtl/mm_rd_tag_pipe.sv
// Read tag pipeline: follows each issued read through the RAM latency and
// steers the returning byte into the owner's registered rvalid/rdata.
module mm_rd_tag_pipe
  import mm_pkg::*;
#(
  parameter int DW     = MM_DW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_valid,
  input  owner_e        push_owner,
  input  logic [DW-1:0] mm_rdata,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata
);

  rd_tag_t tags [RD_LAT+1];
  rd_tag_t tail;
  logic    tail_cpu;
  logic    tail_vga;

  assign tail     = tags[RD_LAT];
  assign tail_cpu = tail.valid && (tail.owner == OWN_CPU);
  assign tail_vga = tail.valid && (tail.owner == OWN_VGA);

  // NOTE: this small tag array is reset on purpose -- a stale valid bit left
  // over from before reset would fabricate a return nobody asked for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RD_LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: push_valid, owner: push_owner};
      for (int i = 1; i <= RD_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  // The tail entry lines up with mm_rdata for the read it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
      vga_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      vga_rdata  <= '0;
    end else begin
      cpu_rvalid <= tail_cpu;
      vga_rvalid <= tail_vga;
      if (tail_cpu) cpu_rdata <= mm_rdata;
      if (tail_vga) vga_rdata <= mm_rdata;
    end
  end

endmodule

// File: rtl/mm_arbiter.sv
// Main-memory read-port arbiter between CPU and VGA scanout; CPU writes pass
// straight to the independent write port.
module mm_arbiter
  import mm_pkg::*;
#(
  parameter int AW         = MM_AW,
  parameter int DW         = MM_DW,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 15
) (
  input logic         clk,
  input logic         rst_n,
  mm_arbiter_if.slave bus
);

  localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic          cpu_rd_req;
  logic          cpu_wr_req;
  logic          cpu_win;
  logic          vga_win;
  rr_state_e     rr_state;
  logic [SW-1:0] starve_cnt;
  logic [AW-1:0] raddr_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic          wren_q;

  assign cpu_rd_req = bus.cpu_req & ~bus.cpu_we;
  assign cpu_wr_req = bus.cpu_req &  bus.cpu_we;

  // NOTE: both winners get a default before any branch so no path leaves
  // them unassigned, which would otherwise infer latches.
  always_comb begin
    cpu_win = 1'b0;
    vga_win = 1'b0;
    if (cpu_rd_req && bus.vga_req) begin
      if (starve_cnt == STARVE_TOP)  cpu_win = 1'b1;
      else if (bus.vga_urgent)       vga_win = 1'b1;
      else if (rr_state == LAST_VGA) cpu_win = 1'b1;
      else                           vga_win = 1'b1;
    end else begin
      cpu_win = cpu_rd_req;
      vga_win = bus.vga_req;
    end
  end

  // Writes use their own RAM port, so they are granted unconditionally.
  assign bus.cpu_gnt  = cpu_wr_req | cpu_win;
  assign bus.vga_gnt  = vga_win;
  assign bus.mm_raddr = raddr_q;
  assign bus.mm_waddr = waddr_q;
  assign bus.mm_wdata = wdata_q;
  assign bus.mm_wren  = wren_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_state   <= LAST_VGA;
      starve_cnt <= '0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
    end else begin
      if (cpu_win)      rr_state <= LAST_CPU;
      else if (vga_win) rr_state <= LAST_VGA;

      if (cpu_rd_req && !cpu_win) begin
        if (starve_cnt != STARVE_TOP) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end

      if (cpu_win)      raddr_q <= bus.cpu_addr;
      else if (vga_win) raddr_q <= bus.vga_addr;

      wren_q <= cpu_wr_req;
      if (cpu_wr_req) begin
        waddr_q <= bus.cpu_addr;
        wdata_q <= bus.cpu_wdata;
      end
    end
  end

  mm_rd_tag_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (cpu_win | vga_win),
    .push_owner (vga_win ? OWN_VGA : OWN_CPU),
    .mm_rdata   (bus.mm_rdata),
    .cpu_rvalid (bus.cpu_rvalid),
    .cpu_rdata  (bus.cpu_rdata),
    .vga_rvalid (bus.vga_rvalid),
    .vga_rdata  (bus.vga_rdata)
  );

endmodule
